// File: rtl/ra_lcb_mphase.sv
// Multi-phase local clock buffer: aligns a phase counter to the array-cycle sync
// pulse, qualifies lock, and emits one-hot maskable strobes with slip diagnostics.
module ra_lcb_mphase #(
    parameter int PHASES   = 2,
    parameter int LOCK_CNT = 2,
    parameter int PW       = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_in,
    input  logic [PHASES-1:0] cfg_phase_en,
    output logic [PHASES-1:0] strobe,
    output logic [PW-1:0]     phase,
    output logic              locked,
    output logic              slip_err,
    output logic [7:0]        slip_cnt
);

    typedef enum logic [1:0] {
        ST_ALIGN,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [3:0]          good_q, good_d;
    logic [PHASES-1:0]   en_q, en_d;
    logic                slip_err_q, slip_err_d;
    logic [7:0]          slip_cnt_q, slip_cnt_d;

    logic [PW-1:0]       phase_inc;
    logic                at_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ALIGN;
            phase_q    <= '0;
            good_q     <= '0;
            en_q       <= '0;
            slip_err_q <= 1'b0;
            slip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            good_q     <= good_d;
            en_q       <= en_d;
            slip_err_q <= slip_err_d;
            slip_cnt_q <= slip_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        good_d     = good_q;
        en_d       = en_q;
        slip_err_d = 1'b0;
        slip_cnt_d = slip_cnt_q;
        phase_inc  = (phase_q == LAST) ? '0 : phase_q + PW'(1);
        at_zero    = (phase_q == '0);

        // Enable mask only changes at the array-cycle boundary while locked
        if (state_q != ST_LOCKED || phase_q == LAST) begin
            en_d = cfg_phase_en;
        end

        case (state_q)
            ST_ALIGN: begin
                if (sync_in) begin
                    phase_d = PW'(1);
                    good_d  = 4'd1;
                    state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (sync_in && at_zero) begin
                    phase_d = phase_inc;
                    if (good_q != 4'hF) begin
                        good_d = good_q + 4'd1;
                    end
                    if (int'(good_q) + 1 >= LOCK_CNT) begin
                        state_d = ST_LOCKED;
                    end
                end else if (sync_in) begin
                    phase_d = PW'(1);
                    good_d  = 4'd1;
                end else if (at_zero) begin
                    state_d = ST_ALIGN;
                    phase_d = '0;
                    good_d  = '0;
                end else begin
                    phase_d = phase_inc;
                end
            end
            ST_LOCKED: begin
                if (sync_in && at_zero) begin
                    phase_d = phase_inc;
                end else if (sync_in || at_zero) begin
                    slip_err_d = 1'b1;
                    if (slip_cnt_q != '1) begin
                        slip_cnt_d = slip_cnt_q + 8'd1;
                    end
                    if (sync_in) begin
                        state_d = ST_VERIFY;
                        phase_d = PW'(1);
                        good_d  = 4'd1;
                    end else begin
                        state_d = ST_ALIGN;
                        phase_d = '0;
                        good_d  = '0;
                    end
                end else begin
                    phase_d = phase_inc;
                end
            end
            default: begin
                state_d = ST_ALIGN;
                phase_d = '0;
                good_d  = '0;
            end
        endcase
    end

    always_comb begin
        strobe = '0;
        for (int unsigned p = 0; p < PHASES; p++) begin
            strobe[p] = (state_q == ST_LOCKED) && (phase_q == PW'(p)) && en_q[p] && !reset;
        end
    end

    assign phase    = phase_q;
    assign locked   = (state_q == ST_LOCKED);
    assign slip_err = slip_err_q;
    assign slip_cnt = slip_cnt_q;

endmodule

// File: tb/tb_ra_lcb_mphase.sv
// Scoreboard bench for ra_lcb_mphase: a 4-phase/LOCK_CNT=2 and a 2-phase/LOCK_CNT=1
// instance driven with randomized sync faults and checked against a lock model.
module tb_ra_lcb_mphase;

    logic       clk = 1'b0;
    logic       reset;
    logic       sync0, sync1;
    logic [3:0] cfg0;
    logic [1:0] cfg1;
    logic [3:0] strobe0;
    logic [1:0] strobe1;
    logic [1:0] phase0;
    logic       phase1;
    logic       locked0, locked1, slip_err0, slip_err1;
    logic [7:0] slip_cnt0, slip_cnt1;

    always #5 clk = ~clk;

    ra_lcb_mphase #(.PHASES(4), .LOCK_CNT(2)) dut0 (
        .clk(clk), .reset(reset), .sync_in(sync0), .cfg_phase_en(cfg0),
        .strobe(strobe0), .phase(phase0), .locked(locked0),
        .slip_err(slip_err0), .slip_cnt(slip_cnt0)
    );

    ra_lcb_mphase #(.PHASES(2), .LOCK_CNT(1)) dut1 (
        .clk(clk), .reset(reset), .sync_in(sync1), .cfg_phase_en(cfg1),
        .strobe(strobe1), .phase(phase1), .locked(locked1),
        .slip_err(slip_err1), .slip_cnt(slip_cnt1)
    );

    typedef struct {
        int strobe;
        int phase;
        int locked;
        int slip_err;
        int slip_cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    // Reference model: per instance, whether a sync reference exists, position in
    // the array cycle, consecutive good syncs, lock flag and the mask in force.
    int       PP[2] = '{4, 2};
    int       LL[2] = '{2, 1};
    bit       al[2], lk[2], se[2];
    int       pos[2], run[2], sc[2];
    bit [3:0] en[2];
    int       gcnt[2];

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s actual=%0h expected=%0h at %0t", d, name, act, exp, $time);
        end
    endtask

    task automatic mreset(input int d);
        al[d] = 0; lk[d] = 0; se[d] = 0;
        pos[d] = 0; run[d] = 0; sc[d] = 0; en[d] = '0;
    endtask

    task automatic mstep(input int d, input bit s, input bit rst, input bit [3:0] cfg);
        bit [3:0] new_en;
        bit       slip;
        if (rst) begin
            mreset(d);
            return;
        end
        slip   = 0;
        new_en = (!lk[d] || pos[d] == PP[d] - 1) ? cfg : en[d];
        if (!al[d]) begin
            if (s) begin
                al[d] = 1; pos[d] = 1 % PP[d]; run[d] = 1;
                lk[d] = (run[d] >= LL[d]);
            end
        end else if (s && pos[d] == 0) begin
            run[d]++;
            if (run[d] >= LL[d]) lk[d] = 1;
            pos[d] = (pos[d] + 1) % PP[d];
        end else if (s) begin
            slip = lk[d];
            run[d] = 1; lk[d] = 0; pos[d] = 1;
        end else if (pos[d] == 0) begin
            slip = lk[d];
            al[d] = 0; run[d] = 0; lk[d] = 0; pos[d] = 0;
        end else begin
            pos[d] = (pos[d] + 1) % PP[d];
        end
        if (slip && sc[d] < 255) sc[d]++;
        se[d] = slip;
        en[d] = new_en;
    endtask

    function automatic exp_t mexp(input int d, input bit rst);
        exp_t e;
        e.strobe   = (lk[d] && !rst) ? ((1 << pos[d]) & int'(en[d])) : 0;
        e.phase    = pos[d];
        e.locked   = lk[d];
        e.slip_err = se[d];
        e.slip_cnt = sc[d];
        return e;
    endfunction

    // Drive one clk cycle of inputs; outputs visible in this cycle are queued first.
    task automatic tick(input bit rst, input bit s0, input bit s1);
        reset = rst;
        sync0 = s0;
        sync1 = s1;
        q0.push_back(mexp(0, rst));
        q1.push_back(mexp(1, rst));
        mstep(0, s0, rst, cfg0);
        mstep(1, s1, rst, {2'b00, cfg1});
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input int d, input bit omit, output bit s);
        s = (gcnt[d] == 0) && !omit;
        gcnt[d] = (gcnt[d] + 1) % PP[d];
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("strobe", 0, int'(strobe0), e.strobe);
            chk("phase", 0, int'(phase0), e.phase);
            chk("locked", 0, int'(locked0), e.locked);
            chk("slip_err", 0, int'(slip_err0), e.slip_err);
            chk("slip_cnt", 0, int'(slip_cnt0), e.slip_cnt);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("strobe", 1, int'(strobe1), e.strobe);
            chk("phase", 1, int'(phase1), e.phase);
            chk("locked", 1, int'(locked1), e.locked);
            chk("slip_err", 1, int'(slip_err1), e.slip_err);
            chk("slip_cnt", 1, int'(slip_cnt1), e.slip_cnt);
        end
    end

    initial begin
        bit s0, s1, hit;
        reset = 1'b1;
        sync0 = 1'b0;
        sync1 = 1'b0;
        cfg0  = 4'hF;
        cfg1  = 2'b11;
        mreset(0);
        mreset(1);
        gcnt[0] = 1;
        gcnt[1] = 1;
        @(posedge clk);
        #1;

        repeat (3) tick(1'b1, 1'b0, 1'b0);

        // Clean lock with full masks, then a mid-cycle mask change
        for (int i = 0; i < 24; i++) begin
            if (i == 13) cfg0 = 4'h5;
            gen(0, 1'b0, s0);
            gen(1, 1'b0, s1);
            tick(1'b0, s0, s1);
        end

        // Randomized sync jitter, dropped syncs, mask changes and rare resets
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 99) < 2) gcnt[d] = $urandom_range(0, PP[d] - 1);
            end
            gen(0, ($urandom_range(0, 99) < 4), s0);
            gen(1, ($urandom_range(0, 99) < 4), s1);
            if ($urandom_range(0, 99) < 5) cfg0 = 4'($urandom);
            if ($urandom_range(0, 99) < 5) cfg1 = 2'($urandom);
            rst = ($urandom_range(0, 999) < 3);
            tick(rst, s0, s1);
        end

        // Reset asserted while phase 2 of the 4-phase instance is strobing
        cfg0 = 4'hF;
        cfg1 = 2'b11;
        hit  = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (lk[0] && pos[0] == 2 && en[0][2]) begin
                hit = 1'b1;
                tick(1'b1, 1'b0, 1'b0);
            end else begin
                gen(0, 1'b0, s0);
                gen(1, 1'b0, s1);
                tick(1'b0, s0, s1);
            end
        end
        chk("reset_mid_strobe_reached", 0, int'(hit), 1);

        // Repeated lock then dropped sync, enough to saturate slip_cnt
        for (int n = 0; n < 300; n++) begin
            gcnt[0] = 0;
            gcnt[1] = 0;
            for (int k = 0; k < 16; k++) begin
                gen(0, (k >= 12), s0);
                gen(1, (k >= 14), s1);
                tick(1'b0, s0, s1);
            end
        end

        for (int i = 0; i < 4; i++) begin
            gen(0, 1'b0, s0);
            gen(1, 1'b0, s1);
            tick(1'b0, s0, s1);
        end
        @(negedge clk);
        chk("slip_cnt_saturated", 0, int'(slip_cnt0), 255);
        chk("slip_cnt_saturated", 1, int'(slip_cnt1), 255);
        chk("queue_drained", 0, q0.size(), 0);
        chk("queue_drained", 1, q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
